// File: rtl/alu_op_arbiter.sv
// alu_op_arbiter: round-robin sharing of one 8-bit ALU between two requesters.
// Each grant drives load, then persist for EXEC_CYCLES, then captures alu_out
// and pulses done for the granted requester.
module alu_op_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       on,
    input  logic       req0,
    input  logic [7:0] num1_0,
    input  logic [7:0] num2_0,
    input  logic [5:0] op_0,
    input  logic       req1,
    input  logic [7:0] num1_1,
    input  logic [7:0] num2_1,
    input  logic [5:0] op_1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] result,
    output logic [2:0] alu_in_sel,
    output logic [7:0] alu_num1,
    output logic [7:0] alu_num2,
    output logic [5:0] alu_out_sel,
    input  logic [7:0] alu_out,
    output logic [1:0] curr_state,
    output logic [1:0] next_state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        EXEC = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

    localparam logic [2:0] SEL_IDLE    = 3'b000;
    localparam logic [2:0] SEL_LOAD    = 3'b010;
    localparam logic [2:0] SEL_PERSIST = 3'b100;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             pick1;

    assign curr_state = state;
    assign next_state = state_nxt;

    // Round-robin winner: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        pick1 = req1;
        if (req0 && req1) begin
            pick1 = ~last_grant;
        end
    end

    // Next-state decode; on only gates the IDLE grant decision.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (on && (req0 || req1)) state_nxt = LOAD;
            LOAD: state_nxt = EXEC;
            EXEC: if (cnt == CNT_LAST) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, counter, grant/done and ALU bus registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= 1'b1;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            result      <= '0;
            alu_in_sel  <= SEL_IDLE;
            alu_num1    <= '0;
            alu_num2    <= '0;
            alu_out_sel <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (state_nxt == LOAD) begin
                        gnt0        <= ~pick1;
                        gnt1        <= pick1;
                        alu_num1    <= pick1 ? num1_1 : num1_0;
                        alu_num2    <= pick1 ? num2_1 : num2_0;
                        alu_out_sel <= pick1 ? op_1 : op_0;
                        alu_in_sel  <= SEL_LOAD;
                    end
                end
                LOAD: begin
                    cnt        <= '0;
                    alu_in_sel <= SEL_PERSIST;
                end
                EXEC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        result     <= alu_out;
                        alu_in_sel <= SEL_IDLE;
                        done0      <= gnt0;
                        done1      <= gnt1;
                        last_grant <= gnt1;
                    end
                end
                DONE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                end
                default: begin
                    alu_in_sel <= SEL_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Directed bench for alu_op_arbiter: one instance with EXEC_CYCLES=1 and one
// with EXEC_CYCLES=4 share all requester inputs; each drives its own ALU model.
module tb_alu_op_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       on;
    logic       req0, req1;
    logic [7:0] num1_0, num2_0, num1_1, num2_1;
    logic [5:0] op_0, op_1;

    logic       gnt0, gnt1, done0, done1;
    logic [7:0] result, alu_num1, alu_num2, alu_out;
    logic [2:0] alu_in_sel;
    logic [5:0] alu_out_sel;
    logic [1:0] curr_state, next_state;

    logic       d4_gnt0, d4_gnt1, d4_done0, d4_done1;
    logic [7:0] d4_result, d4_alu_num1, d4_alu_num2, d4_alu_out;
    logic [2:0] d4_alu_in_sel;
    logic [5:0] d4_alu_out_sel;
    logic [1:0] d4_curr_state, d4_next_state;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Reference ALU: 1 add, 2 subtract, 3 and, anything else xor.
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
        case (op)
            6'd1:    return a + b;
            6'd2:    return a - b;
            6'd3:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_out    = alu_f(alu_num1, alu_num2, alu_out_sel);
    assign d4_alu_out = alu_f(d4_alu_num1, d4_alu_num2, d4_alu_out_sel);

    alu_op_arbiter #(.EXEC_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .on(on),
        .req0(req0), .num1_0(num1_0), .num2_0(num2_0), .op_0(op_0),
        .req1(req1), .num1_1(num1_1), .num2_1(num2_1), .op_1(op_1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .alu_in_sel(alu_in_sel), .alu_num1(alu_num1),
        .alu_num2(alu_num2), .alu_out_sel(alu_out_sel), .alu_out(alu_out),
        .curr_state(curr_state), .next_state(next_state)
    );

    alu_op_arbiter #(.EXEC_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .on(on),
        .req0(req0), .num1_0(num1_0), .num2_0(num2_0), .op_0(op_0),
        .req1(req1), .num1_1(num1_1), .num2_1(num2_1), .op_1(op_1),
        .gnt0(d4_gnt0), .gnt1(d4_gnt1), .done0(d4_done0), .done1(d4_done1),
        .result(d4_result), .alu_in_sel(d4_alu_in_sel), .alu_num1(d4_alu_num1),
        .alu_num2(d4_alu_num2), .alu_out_sel(d4_alu_out_sel), .alu_out(d4_alu_out),
        .curr_state(d4_curr_state), .next_state(d4_next_state)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("one_gnt", 8'(gnt0 & gnt1), 8'h00);
        chk("one_done", 8'(done0 & done1), 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; on = 1'b1; req0 = 1'b0; req1 = 1'b0;
        num1_0 = '0; num2_0 = '0; op_0 = '0;
        num1_1 = '0; num2_1 = '0; op_1 = '0;
        do_reset();

        // Reset state
        chk("rst_state", 8'(curr_state), 8'h00);
        chk("rst_result", result, 8'h00);
        chk("rst_gnt", 8'({gnt0, gnt1, done0, done1}), 8'h00);
        chk("rst_alu_num1", alu_num1, 8'h00);
        chk("rst_in_sel", 8'(alu_in_sel), 8'h00);

        // Single req0: 57+1A=71; the EXEC_CYCLES=4 instance runs alongside
        req0 = 1'b1; num1_0 = 8'h57; num2_0 = 8'h1A; op_0 = 6'd1;
        step();                                  // grant edge k
        chk("p1_state_load", 8'(curr_state), 8'h01);
        chk("p1_in_sel_load", 8'(alu_in_sel), 8'h02);
        chk("p1_gnt0", 8'(gnt0), 8'h01);
        chk("p1_gnt1", 8'(gnt1), 8'h00);
        chk("p1_alu_num1", alu_num1, 8'h57);
        chk("p1_alu_num2", alu_num2, 8'h1A);
        chk("p1_alu_op", 8'(alu_out_sel), 8'h01);
        chk("p1_next_exec", 8'(next_state), 8'h02);
        chk("p1_d4_in_sel_load", 8'(d4_alu_in_sel), 8'h02);
        step();                                  // k+1
        chk("p1_in_sel_exec", 8'(alu_in_sel), 8'h04);
        chk("p1_next_done", 8'(next_state), 8'h03);
        chk("p1_done0_early", 8'(done0), 8'h00);
        chk("p1_d4_in_sel_exec1", 8'(d4_alu_in_sel), 8'h04);
        chk("p1_d4_next_exec", 8'(d4_next_state), 8'h02);
        step();                                  // k+2
        chk("p1_state_done", 8'(curr_state), 8'h03);
        chk("p1_in_sel_done", 8'(alu_in_sel), 8'h00);
        chk("p1_done0", 8'(done0), 8'h01);
        chk("p1_done1", 8'(done1), 8'h00);
        chk("p1_result", result, 8'h71);
        chk("p1_d4_in_sel_exec2", 8'(d4_alu_in_sel), 8'h04);
        req0 = 1'b0;                             // dropped mid-op for dut4
        step();                                  // k+3
        chk("p1_state_idle", 8'(curr_state), 8'h00);
        chk("p1_done0_clear", 8'(done0), 8'h00);
        chk("p1_gnt0_clear", 8'(gnt0), 8'h00);
        chk("p1_result_hold", result, 8'h71);
        chk("p1_d4_in_sel_exec3", 8'(d4_alu_in_sel), 8'h04);
        step();                                  // k+4
        chk("p1_d4_in_sel_exec4", 8'(d4_alu_in_sel), 8'h04);
        chk("p1_d4_done0_early", 8'(d4_done0), 8'h00);
        chk("p1_d4_next_done", 8'(d4_next_state), 8'h03);
        step();                                  // k+5
        chk("p1_d4_state_done", 8'(d4_curr_state), 8'h03);
        chk("p1_d4_in_sel_done", 8'(d4_alu_in_sel), 8'h00);
        chk("p1_d4_done0", 8'(d4_done0), 8'h01);
        chk("p1_d4_result", d4_result, 8'h71);
        step();                                  // k+6
        chk("p1_d4_idle", 8'(d4_curr_state), 8'h00);
        chk("p1_d4_done0_clear", 8'(d4_done0), 8'h00);

        // Simultaneous requests: grants alternate starting with requester 0
        do_reset();
        req0 = 1'b1; num1_0 = 8'h10; num2_0 = 8'h20; op_0 = 6'd1;  // 30
        req1 = 1'b1; num1_1 = 8'h50; num2_1 = 8'h13; op_1 = 6'd2;  // 3D
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_gnt0", 8'(gnt0), 8'((i % 2) == 0));
            chk("rr_gnt1", 8'(gnt1), 8'((i % 2) == 1));
            step();
            step();
            chk("rr_done0", 8'(done0), 8'((i % 2) == 0));
            chk("rr_done1", 8'(done1), 8'((i % 2) == 1));
            chk("rr_result", result, ((i % 2) == 0) ? 8'h30 : 8'h3D);
            step();
        end
        req0 = 1'b0; req1 = 1'b0;

        // Operand change after grant is ignored: 05 & 03 = 01
        do_reset();
        req1 = 1'b1; num1_1 = 8'h05; num2_1 = 8'h03; op_1 = 6'd3;
        step();
        chk("oc_gnt1", 8'(gnt1), 8'h01);
        chk("oc_num1_load", alu_num1, 8'h05);
        num1_1 = 8'hFF;
        step();
        chk("oc_num1_exec", alu_num1, 8'h05);
        step();
        chk("oc_num1_done", alu_num1, 8'h05);
        chk("oc_done1", 8'(done1), 8'h01);
        chk("oc_result", result, 8'h01);
        req1 = 1'b0;
        step();

        // on=0 blocks grants; dropping on mid-op lets it finish. 0F ^ F0 = FF
        do_reset();
        on = 1'b0;
        req0 = 1'b1; num1_0 = 8'h0F; num2_0 = 8'hF0; op_0 = 6'd7;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("off_state", 8'(curr_state), 8'h00);
            chk("off_gnt0", 8'(gnt0), 8'h00);
            chk("off_next", 8'(next_state), 8'h00);
        end
        on = 1'b1;
        step();
        chk("on_gnt0", 8'(gnt0), 8'h01);
        step();
        chk("on_exec", 8'(curr_state), 8'h02);
        on = 1'b0;
        step();
        chk("off_mid_done0", 8'(done0), 8'h01);
        chk("off_mid_result", result, 8'hFF);
        step();
        step();
        chk("off_after_state", 8'(curr_state), 8'h00);
        chk("off_after_gnt0", 8'(gnt0), 8'h00);

        // Asynchronous reset mid-EXEC, then priority after release
        on = 1'b1;
        num1_0 = 8'h22; num2_0 = 8'h11; op_0 = 6'd1;
        step();
        step();
        chk("ar_exec", 8'(curr_state), 8'h02);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_state", 8'(curr_state), 8'h00);
        chk("ar_result", result, 8'h00);
        chk("ar_gnt_done", 8'({gnt0, gnt1, done0, done1}), 8'h00);
        chk("ar_in_sel", 8'(alu_in_sel), 8'h00);
        chk("ar_alu_num1", alu_num1, 8'h00);
        req1 = 1'b1; num1_1 = 8'h09; num2_1 = 8'h04; op_1 = 6'd2;  // 05
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        chk("ar_tie_gnt0", 8'(gnt0), 8'h01);
        chk("ar_tie_gnt1", 8'(gnt1), 8'h00);
        req0 = 1'b0;
        step();
        step();
        chk("ar_done0", 8'(done0), 8'h01);
        chk("ar_result0", result, 8'h33);
        step();
        step();
        chk("ar_solo_gnt1", 8'(gnt1), 8'h01);
        chk("ar_solo_num1", alu_num1, 8'h09);
        step();
        step();
        chk("ar_done1", 8'(done1), 8'h01);
        chk("ar_result1", result, 8'h05);
        req1 = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
